deser_lane_arbiter: RTL



---
 rtl/deser_lane_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/deser_lane_arbiter.sv
// Round-robin arbiter that lends one shared serial deserializer to N_LANES
// sources, one WORD_W-bit word per grant, returning the word tagged by lane.

module deser_lane_slot #(
    parameter int LW  = 2,
    parameter int IDX = 0
) (
    input  logic          req,
    input  logic [LW-1:0] rr_ptr,
    output logic          hi_req
);
    // Request that sits at or above the round-robin pointer wins before wrap.
    assign hi_req = req && (LW'(IDX) >= rr_ptr);
endmodule

module deser_lane_arbiter #(
    parameter int N_LANES  = 4,
    parameter int WORD_W   = 16,
    parameter int WAIT_MAX = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic [N_LANES-1:0]         req_i,
    input  logic [N_LANES-1:0]         data_i,
    input  logic [N_LANES-1:0]         data_val_i,
    output logic [N_LANES-1:0]         gnt_o,
    output logic                       ser_data_o,
    output logic                       ser_data_val_o,
    output logic                       deser_flush_o,
    input  logic [WORD_W-1:0]          deser_data_i,
    input  logic                       deser_data_val_i,
    output logic [WORD_W-1:0]          word_o,
    output logic [$clog2(N_LANES)-1:0] word_lane_o,
    output logic                       word_val_o,
    output logic                       err_o
);
    localparam int LW = $clog2(N_LANES);
    localparam int BW = $clog2(WORD_W) + 1;
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_FLUSH} state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   lane, lane_nxt;
    logic [LW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [WW-1:0]   wait_cnt, wait_cnt_nxt;

    logic [N_LANES-1:0] gnt_nxt;
    logic               ser_data_nxt, ser_val_nxt, flush_nxt, err_nxt, word_val_nxt;
    logic [WORD_W-1:0]  word_nxt;
    logic [LW-1:0]      word_lane_nxt;

    logic [N_LANES-1:0] hi_req;
    logic [LW-1:0]      pick, lane_inc;
    logic               req_sel, val_sel, dat_sel;
    logic               bit_acc, last_bit, abort, word_hit, tmo;

    for (genvar g = 0; g < N_LANES; g++) begin : g_slot
        deser_lane_slot #(.LW(LW), .IDX(g)) u_slot (
            .req    (req_i[g]),
            .rr_ptr (rr_ptr),
            .hi_req (hi_req[g])
        );
    end

    // Lowest requester at/above rr_ptr; otherwise wrap to lowest requester overall.
    always_comb begin
        pick = '0;
        for (int i = N_LANES - 1; i >= 0; i--)
            if (req_i[i]) pick = LW'(i);
        for (int i = N_LANES - 1; i >= 0; i--)
            if (hi_req[i]) pick = LW'(i);
    end

    assign lane_inc = (lane == LW'(N_LANES - 1)) ? '0 : lane + 1'b1;
    assign req_sel  = req_i[lane];
    assign val_sel  = data_val_i[lane];
    assign dat_sel  = data_i[lane];

    // A dropped request wins over a same-cycle valid bit: that bit is discarded.
    assign abort    = (state == S_STREAM) && !req_sel;
    assign bit_acc  = (state == S_STREAM) && req_sel && val_sel;
    assign last_bit = bit_acc && (bit_cnt == BW'(WORD_W - 1));
    assign word_hit = (state == S_WAIT) && deser_data_val_i;
    assign tmo      = (state == S_WAIT) && !deser_data_val_i
                      && (wait_cnt == WW'(WAIT_MAX - 1));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|req_i) state_nxt = S_STREAM;
            S_STREAM: if (abort) state_nxt = S_FLUSH;
                      else if (last_bit) state_nxt = S_WAIT;
            S_WAIT:   if (word_hit) state_nxt = S_IDLE;
                      else if (tmo) state_nxt = S_FLUSH;
            S_FLUSH:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; flush/err are set on entry to
    // FLUSH so they are high for exactly the one FLUSH cycle.
    always_comb begin
        gnt_nxt       = gnt_o;
        ser_data_nxt  = ser_data_o;
        ser_val_nxt   = 1'b0;
        flush_nxt     = 1'b0;
        err_nxt       = 1'b0;
        word_nxt      = word_o;
        word_lane_nxt = word_lane_o;
        word_val_nxt  = 1'b0;
        lane_nxt      = lane;
        rr_ptr_nxt    = rr_ptr;
        bit_cnt_nxt   = bit_cnt;
        wait_cnt_nxt  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (|req_i) begin
                    lane_nxt      = pick;
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    bit_cnt_nxt   = '0;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    gnt_nxt    = '0;
                    flush_nxt  = 1'b1;
                    err_nxt    = 1'b1;
                    rr_ptr_nxt = lane_inc;
                end else if (bit_acc) begin
                    ser_data_nxt = dat_sel;
                    ser_val_nxt  = 1'b1;
                    bit_cnt_nxt  = bit_cnt + 1'b1;
                    if (last_bit) wait_cnt_nxt = '0;
                end
            end
            S_WAIT: begin
                if (word_hit) begin
                    word_nxt      = deser_data_i;
                    word_lane_nxt = lane;
                    word_val_nxt  = 1'b1;
                    gnt_nxt       = '0;
                    rr_ptr_nxt    = lane_inc;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                    if (tmo) begin
                        gnt_nxt    = '0;
                        flush_nxt  = 1'b1;
                        err_nxt    = 1'b1;
                        rr_ptr_nxt = lane_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            gnt_o          <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            deser_flush_o  <= 1'b0;
            err_o          <= 1'b0;
            word_o         <= '0;
            word_lane_o    <= '0;
            word_val_o     <= 1'b0;
            lane           <= '0;
            rr_ptr         <= '0;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
        end else begin
            gnt_o          <= gnt_nxt;
            ser_data_o     <= ser_data_nxt;
            ser_data_val_o <= ser_val_nxt;
            deser_flush_o  <= flush_nxt;
            err_o          <= err_nxt;
            word_o         <= word_nxt;
            word_lane_o    <= word_lane_nxt;
            word_val_o     <= word_val_nxt;
            lane           <= lane_nxt;
            rr_ptr         <= rr_ptr_nxt;
            bit_cnt        <= bit_cnt_nxt;
            wait_cnt       <= wait_cnt_nxt;
        end
    end
endmodule
